// File: rtl/ysyx_25040109_mdu.sv
// Iterative RV32M/RV64M multiply/divide unit: shift-add multiply and restoring divide,
// STEPS iterations per clock, with registered fast paths for divide-by-zero and overflow.
module ysyx_25040109_mdu #(
    parameter int XLEN  = 32,
    parameter int STEPS = 1,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_funct3,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int ITERS = XLEN / STEPS;
    localparam int CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITERS - 1);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state, state_next;
    logic [CNT_W-1:0]  counter;
    logic [2:0]        funct3_r;
    logic              sign_a, sign_b;
    logic [XLEN-1:0]   hi, lo, opb;
    logic [XLEN-1:0]   hi_step, lo_step;
    logic [XLEN-1:0]   result_r, result_done;
    logic [TAG_W-1:0]  tag_r;
    logic              accept, last_step;
    logic              a_signed, b_signed, in_sign_a, in_sign_b, is_fast;
    logic [XLEN-1:0]   mag_a, mag_b, fast_result;
    logic [XLEN:0]     sum, rem_sh;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, remv;

    assign in_ready   = (state == IDLE) && !flush;
    assign accept     = in_valid && in_ready;
    assign out_valid  = (state == DONE);
    assign busy       = (state != IDLE);
    assign out_result = result_r;
    assign out_tag    = tag_r;
    assign last_step  = (counter == CNT_LAST);

    // Magnitude conversion and special-case detection on the incoming request
    always_comb begin
        a_signed    = (in_funct3 == 3'd1) || (in_funct3 == 3'd2) ||
                      (in_funct3 == 3'd4) || (in_funct3 == 3'd6);
        b_signed    = (in_funct3 == 3'd1) || (in_funct3 == 3'd4) || (in_funct3 == 3'd6);
        in_sign_a   = a_signed && in_rs1[XLEN-1];
        in_sign_b   = b_signed && in_rs2[XLEN-1];
        mag_a       = in_sign_a ? -in_rs1 : in_rs1;
        mag_b       = in_sign_b ? -in_rs2 : in_rs2;
        is_fast     = 1'b0;
        fast_result = '0;
        if (in_funct3[2]) begin
            if (in_rs2 == '0) begin
                is_fast     = 1'b1;
                fast_result = in_funct3[1] ? in_rs1 : '1;
            end else if (!in_funct3[0] && (in_rs1 == MOST_NEG) && (in_rs2 == '1)) begin
                is_fast     = 1'b1;
                fast_result = in_funct3[1] ? '0 : MOST_NEG;
            end
        end
    end

    // STEPS unrolled iterations; lo holds the multiplier or the dividend/quotient
    always_comb begin
        hi_step = hi;
        lo_step = lo;
        sum     = '0;
        rem_sh  = '0;
        for (int i = 0; i < STEPS; i++) begin
            if (funct3_r[2]) begin
                rem_sh  = {hi_step, lo_step[XLEN-1]};
                lo_step = {lo_step[XLEN-2:0], (rem_sh >= {1'b0, opb})};
                hi_step = (rem_sh >= {1'b0, opb}) ? XLEN'(rem_sh - {1'b0, opb})
                                                  : rem_sh[XLEN-1:0];
            end else begin
                sum     = {1'b0, hi_step} + (lo_step[0] ? {1'b0, opb} : '0);
                hi_step = sum[XLEN:1];
                lo_step = {sum[0], lo_step[XLEN-1:1]};
            end
        end
    end

    always_comb begin
        prod = (sign_a ^ sign_b) ? -{hi_step, lo_step} : {hi_step, lo_step};
        quo  = (sign_a ^ sign_b) ? -lo_step : lo_step;
        remv = sign_a ? -hi_step : hi_step;
        if (funct3_r[2]) begin
            result_done = funct3_r[1] ? remv : quo;
        end else begin
            result_done = (funct3_r[1:0] == 2'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state_next = is_fast ? DONE : CALC;
                CALC:    if (last_step) state_next = DONE;
                DONE:    if (out_ready) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Datapath: operands captured at accept, iterated in CALC, result frozen in DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter  <= '0;
            funct3_r <= '0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            opb      <= '0;
            result_r <= '0;
            tag_r    <= '0;
        end else if (accept) begin
            counter  <= '0;
            funct3_r <= in_funct3;
            sign_a   <= in_sign_a;
            sign_b   <= in_sign_b;
            hi       <= '0;
            lo       <= mag_a;
            opb      <= mag_b;
            tag_r    <= in_tag;
            if (is_fast) result_r <= fast_result;
        end else if (state == CALC && !flush) begin
            hi <= hi_step;
            lo <= lo_step;
            if (last_step) begin
                result_r <= result_done;
            end else begin
                counter <= counter + CNT_W'(1);
            end
        end
    end

endmodule
